time_uart_tx: RTL and testbench

Reads the packed BCD real-time value (data_ch) and transmits it as the ASCII line "HH:MM:SS\r\n" over a UART 8N1 serial output. It is the read-out counterpart to the time-setup path, which writes time into the real-time clock. A transmission starts on a button pulse, or automatically whenever the time value changes. It sits beside the real-time clock in the top level and drives one output pin.

---
 rtl/chasy_pkg.sv | 49 ++++
 rtl/uart_tx_byte.sv | 98 +++++++++
 rtl/time_uart_tx.sv | 70 +++++++
 tb/tb_time_uart_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chasy_pkg.sv
// Shared types and ASCII constants for the real-time clock read-out path.
package chasy_pkg;

  typedef struct packed {
    logic [3:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [3:0] LAST_CHAR   = 4'd9;

  // Non-decimal nibbles are reported as '?' rather than as punctuation.
  function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? 8'(ASCII_ZERO + {4'h0, nib}) : ASCII_QMARK;
  endfunction

  function automatic logic [7:0] frame_char(input bcd_time_t t, input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = bcd_ascii(t.h1);
      4'd1:    c = bcd_ascii(t.h0);
      4'd2:    c = ASCII_COLON;
      4'd3:    c = bcd_ascii(t.m1);
      4'd4:    c = bcd_ascii(t.m0);
      4'd5:    c = ASCII_COLON;
      4'd6:    c = bcd_ascii(t.s1);
      4'd7:    c = bcd_ascii(t.s0);
      4'd8:    c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready rises in the last stop-bit cycle so bytes chain with no gap.
module uart_tx_byte
  import chasy_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  uart_state_e      state, state_n;
  logic [CNT_W-1:0] baud_cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= cnt_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // Shift register is pre-shifted so the next data bit is always shift[0].
  always_comb begin
    state_n = state;
    cnt_n   = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx;
    ready   = 1'b0;
    if (state != UART_IDLE) cnt_n = bit_end ? '0 : CNT_W'(baud_cnt + 1'b1);
    case (state)
      UART_IDLE: begin
        ready = 1'b1;
        cnt_n = '0;
        if (valid) begin
          state_n = UART_START;
          shift_n = data;
          tx_n    = 1'b0;
        end
      end
      UART_START: begin
        if (bit_end) begin
          state_n = UART_DATA;
          bit_n   = 3'd0;
          tx_n    = shift[0];
          shift_n = {1'b1, shift[7:1]};
        end
      end
      UART_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_n = UART_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = 3'(bit_idx + 3'd1);
            tx_n    = shift[0];
            shift_n = {1'b1, shift[7:1]};
          end
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          ready = 1'b1;
          if (valid) begin
            state_n = UART_START;
            shift_n = data;
            tx_n    = 1'b0;
          end else begin
            state_n = UART_IDLE;
          end
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

endmodule

// File: rtl/time_uart_tx.sv
// Sends the BCD time as "HH:MM:SS\r\n" over UART on a button pulse or on any time change.
module time_uart_tx
  import chasy_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data_ch,
  input  logic        send,
  input  logic        auto_en,
  output logic        tx,
  output logic        busy
);

  bcd_time_t   frame_reg;
  bcd_time_t   live;
  logic [23:0] prev_data;
  logic [3:0]  char_idx;
  logic        pending;
  logic        trigger_c;
  logic        start_c;
  logic        valid_c;
  logic        ready_c;
  logic [7:0]  char_c;

  assign live      = bcd_time_t'(data_ch);
  assign trigger_c = send || (auto_en && (data_ch != prev_data));
  assign start_c   = !busy && (trigger_c || pending);

  // First character comes straight from data_ch so the start bit appears the cycle after the trigger.
  assign char_c  = busy ? frame_char(frame_reg, 4'(char_idx + 4'd1)) : frame_char(live, 4'd0);
  assign valid_c = start_c || (busy && (char_idx != LAST_CHAR));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_data <= '0;
      frame_reg <= '0;
      char_idx  <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      prev_data <= data_ch;
      if (start_c) begin
        frame_reg <= live;
        char_idx  <= '0;
        pending   <= 1'b0;
        busy      <= 1'b1;
      end else if (busy) begin
        if (trigger_c) pending <= 1'b1;
        if (ready_c) begin
          if (char_idx == LAST_CHAR) busy <= 1'b0;
          else char_idx <= 4'(char_idx + 4'd1);
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte (
    .clock(clock),
    .reset(reset),
    .data (char_c),
    .valid(valid_c),
    .ready(ready_c),
    .tx   (tx)
  );

endmodule

// File: tb/tb_time_uart_tx.sv
// Bench for time_uart_tx: decodes the serial line and scores each character against expected lines.
module tb_time_uart_tx;

  localparam int unsigned B = 4;

  logic        clock;
  logic        reset;
  logic [23:0] data_ch;
  logic        send;
  logic        auto_en;
  logic        tx;
  logic        busy;

  int          n_checks;
  int          n_fail;
  logic [7:0]  exp_q[$];
  bit          mon_en;

  typedef struct {
    logic [23:0] data;
    logic [79:0] line;
  } vec_t;

  vec_t vecs[5];

  time_uart_tx #(.BAUD_DIV(B)) dut (
    .clock  (clock),
    .reset  (reset),
    .data_ch(data_ch),
    .send   (send),
    .auto_en(auto_en),
    .tx     (tx),
    .busy   (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_line(input logic [79:0] line);
    for (int k = 0; k < 10; k++) exp_q.push_back(line[79-8*k -: 8]);
  endtask

  task automatic pulse_send;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int budget, output int n);
    n = 0;
    while (busy !== level && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_busy: busy=%b expected %b within %0d cycles", busy, level, budget);
    end
  endtask

  task automatic run_cycles(input int n, output int rises, output int tx_low);
    logic prev_b;
    rises  = 0;
    tx_low = 0;
    prev_b = busy;
    for (int i = 0; i < n; i++) begin
      tick();
      if (busy === 1'b1 && prev_b !== 1'b1) rises++;
      if (tx !== 1'b1) tx_low++;
      prev_b = busy;
    end
  endtask

  // Serial decoder: samples each bit mid-period and pops the matching expected byte.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        repeat (B / 2) @(negedge clock);
        bits[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (B) @(negedge clock);
          bits[i] = tx;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_char: got %0h expected none", bits[8:1]);
        end else begin
          e = exp_q.pop_front();
          check("uart_char", {22'd0, bits}, {22'd0, 1'b1, e, 1'b0});
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, g, r, tl;
    vecs[0] = '{data: 24'h123456, line: "12:34:56\r\n"};
    vecs[1] = '{data: 24'h23595A, line: "23:59:5?\r\n"};
    vecs[2] = '{data: 24'h000000, line: "00:00:00\r\n"};
    vecs[3] = '{data: 24'hFFFFFF, line: "??:??:??\r\n"};
    vecs[4] = '{data: 24'h09A9B9, line: "09:?9:?9\r\n"};

    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b1;
    reset    = 1'b0;
    send     = 1'b0;
    auto_en  = 1'b0;
    data_ch  = 24'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    tick();

    // Manual send with several patterns, including non-decimal nibbles.
    for (int v = 0; v < 5; v++) begin
      data_ch = vecs[v].data;
      tick();
      tick();
      push_line(vecs[v].line);
      pulse_send();
      check("start_tx", 32'(tx), 32'd0);
      check("start_busy", 32'(busy), 32'd1);
      wait_busy(1'b0, 1000, n);
      check("busy_len", 32'(n), 32'd400);
      repeat (5) tick();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
    end

    // Auto mode: a single step of data_ch gives exactly one frame.
    data_ch = 24'h000000;
    tick();
    tick();
    auto_en = 1'b1;
    tick();
    push_line("00:00:01\r\n");
    data_ch = 24'h000001;
    run_cycles(900, r, tl);
    check("auto_frames", 32'(r), 32'd1);
    check("auto_queue", 32'(exp_q.size()), 32'd0);

    // Same step with auto mode off must leave the line idle.
    auto_en = 1'b0;
    data_ch = 24'h000000;
    tick();
    tick();
    data_ch = 24'h000001;
    run_cycles(500, r, tl);
    check("noauto_frames", 32'(r), 32'd0);
    check("noauto_tx_low", 32'(tl), 32'd0);

    // Triggers during a frame collapse into one follow-up frame with a fresh snapshot.
    data_ch = 24'h123456;
    tick();
    tick();
    push_line("12:34:56\r\n");
    pulse_send();
    check("mid_start_busy", 32'(busy), 32'd1);
    repeat (50) tick();
    repeat (3) begin
      pulse_send();
      tick();
    end
    data_ch = 24'h101010;
    push_line("10:10:10\r\n");
    wait_busy(1'b0, 1000, n);
    wait_busy(1'b1, 10, g);
    check("mid_gap", 32'(g), 32'd1);
    wait_busy(1'b0, 1000, n);
    check("mid_second_len", 32'(n), 32'd400);
    run_cycles(500, r, tl);
    check("mid_extra_frames", 32'(r), 32'd0);
    check("mid_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame takes effect immediately.
    mon_en  = 1'b0;
    data_ch = 24'h123456;
    tick();
    tick();
    pulse_send();
    repeat (150) tick();
    check("pre_reset_tx", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    run_cycles(500, r, tl);
    check("post_reset_frames", 32'(r), 32'd0);
    check("post_reset_tx_low", 32'(tl), 32'd0);
    mon_en = 1'b1;

    // Send and a data change in the same cycle produce one frame only.
    auto_en = 1'b1;
    tick();
    tick();
    data_ch = 24'h235959;
    send    = 1'b1;
    push_line("23:59:59\r\n");
    tick();
    send = 1'b0;
    check("simul_start_tx", 32'(tx), 32'd0);
    check("simul_start_busy", 32'(busy), 32'd1);
    wait_busy(1'b0, 1000, n);
    check("simul_busy_len", 32'(n), 32'd400);
    run_cycles(500, r, tl);
    check("simul_extra_frames", 32'(r), 32'd0);
    check("simul_queue", 32'(exp_q.size()), 32'd0);
    auto_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
